// File: rtl/traffic_controller_nway.sv
// N-direction intersection controller: GREEN -> YELLOW -> ALL_RED rotation with optional
// demand actuation and emergency pre-emption. Lamp codes are registered from the next phase/direction.
module traffic_controller_nway #(
    parameter int NUM_DIR      = 4,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int ACTUATED     = 0,
    localparam int DIR_W       = $clog2(NUM_DIR)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_en,
    input  logic [NUM_DIR-1:0]   car_req,
    input  logic                 emerg_req,
    input  logic [DIR_W-1:0]     emerg_dir,
    output logic [2*NUM_DIR-1:0] lights,
    output logic [DIR_W-1:0]     cur_dir,
    output logic [1:0]           phase,
    output logic                 emerg_act
);

    localparam int MAX_TICKS = (GREEN_TICKS > YELLOW_TICKS)
                             ? ((GREEN_TICKS > ALLRED_TICKS) ? GREEN_TICKS : ALLRED_TICKS)
                             : ((YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS);
    localparam int TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    // Encodings double as the externally visible phase code.
    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_GREEN   = 2'b10
    } phase_t;

    phase_t               phase_q, phase_d;
    logic [DIR_W-1:0]     dir_q, dir_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_DIR-1:0]   pending_q, pending_d;
    logic                 act_q, act_d;
    logic                 hold_q, hold_d;
    logic [2*NUM_DIR-1:0] lights_q, lights_d;

    logic [NUM_DIR-1:0]   eff_pending;
    logic [NUM_DIR-1:0]   clear_mask;
    logic                 emerg_valid;
    logic                 go_green;
    logic [DIR_W-1:0]     green_dir;
    logic [DIR_W-1:0]     next_fixed;
    logic [DIR_W-1:0]     scan_dir;
    logic [DIR_W-1:0]     cand;
    logic                 scan_found;

    function automatic logic [DIR_W-1:0] wrap_inc(input logic [DIR_W-1:0] d);
        return (d == DIR_W'(NUM_DIR - 1)) ? '0 : d + DIR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q   <= PH_ALL_RED;
            dir_q     <= DIR_W'(NUM_DIR - 1);
            timer_q   <= TW'(ALLRED_TICKS - 1);
            pending_q <= '0;
            act_q     <= 1'b0;
            hold_q    <= 1'b0;
            lights_q  <= '0;
        end else begin
            phase_q   <= phase_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            act_q     <= act_d;
            hold_q    <= hold_d;
            lights_q  <= lights_d;
        end
    end

    // Demand scan looks at this cycle's requests too, so a waiting ALL_RED leaves immediately.
    always_comb begin
        eff_pending = pending_q | car_req;
        emerg_valid = emerg_req && ({1'b0, emerg_dir} < (DIR_W + 1)'(NUM_DIR));
        next_fixed  = wrap_inc(dir_q);
        scan_found  = 1'b0;
        scan_dir    = dir_q;
        cand        = dir_q;
        for (int k = 0; k < NUM_DIR; k++) begin
            cand = wrap_inc(cand);
            if (!scan_found && eff_pending[cand]) begin
                scan_found = 1'b1;
                scan_dir   = cand;
            end
        end
    end

    always_comb begin
        phase_d    = phase_q;
        dir_d      = dir_q;
        timer_d    = timer_q;
        act_d      = act_q;
        hold_d     = hold_q;
        go_green   = 1'b0;
        green_dir  = dir_q;
        clear_mask = '0;

        case (phase_q)
            PH_ALL_RED: begin
                if (timer_q == '0 && (tick_en || hold_q)) begin
                    if (emerg_valid) begin
                        go_green  = 1'b1;
                        green_dir = emerg_dir;
                        act_d     = 1'b1;
                    end else if (ACTUATED == 0) begin
                        go_green  = 1'b1;
                        green_dir = next_fixed;
                    end else if (scan_found) begin
                        go_green  = 1'b1;
                        green_dir = scan_dir;
                    end else begin
                        hold_d = 1'b1;
                    end
                end else if (tick_en && timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end
            end
            PH_GREEN: begin
                if (emerg_valid && emerg_dir != dir_q) begin
                    phase_d = PH_YELLOW;
                    timer_d = TW'(YELLOW_TICKS - 1);
                    act_d   = 1'b0;
                end else if (emerg_valid) begin
                    act_d = 1'b1;
                end else if (act_q) begin
                    // Emergency withdrawn: leave at once rather than finishing the GREEN.
                    phase_d = PH_YELLOW;
                    timer_d = TW'(YELLOW_TICKS - 1);
                    act_d   = 1'b0;
                end else if (tick_en) begin
                    if (timer_q == '0) begin
                        phase_d = PH_YELLOW;
                        timer_d = TW'(YELLOW_TICKS - 1);
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            PH_YELLOW: begin
                if (tick_en) begin
                    if (timer_q == '0) begin
                        phase_d = PH_ALL_RED;
                        timer_d = TW'(ALLRED_TICKS - 1);
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            default: begin
                phase_d = PH_ALL_RED;
                timer_d = TW'(ALLRED_TICKS - 1);
                act_d   = 1'b0;
            end
        endcase

        if (go_green) begin
            phase_d               = PH_GREEN;
            dir_d                 = green_dir;
            timer_d               = TW'(GREEN_TICKS - 1);
            hold_d                = 1'b0;
            clear_mask[green_dir] = 1'b1;
        end
    end

    // Clear wins over a coincident set for the direction entering GREEN.
    always_comb begin
        pending_d = (pending_q | car_req) & ~clear_mask;
        lights_d  = '0;
        case (phase_d)
            PH_GREEN:  lights_d[{dir_d, 1'b0} +: 2] = 2'b10;
            PH_YELLOW: lights_d[{dir_d, 1'b0} +: 2] = 2'b01;
            default:   lights_d = '0;
        endcase
    end

    assign lights    = lights_q;
    assign cur_dir   = dir_q;
    assign phase     = phase_q;
    assign emerg_act = act_q;

endmodule
